// File: rtl/rocket_launch_manager.sv
// ----------------------------------------------------------------------------
// rocket_launch_manager
//
// Issuing side of the rocket activation interface. Owns a pool of NUM_ROCKETS
// rocket-controller slots. On a fire request it picks the lowest free slot,
// raises that slot's active enable and drives the shared launch bus with the
// launch position and speed. A slot is released when its controller reports
// a border crossing or a hit. After each launch a frame-based cooldown
// blocks further launches.
//
// Ports
//   i_clk              system clock
//   i_rst_n            asynchronous reset, active low
//   i_start_of_frame   one-clock pulse per video frame
//   i_fire_request     level, ship wants to fire
//   i_ship_x/y         ship top-left position (11-bit signed)
//   i_reached_border   per-slot border flag from the rocket controllers
//   i_rocket_hit       per-slot collision pulse
//   o_is_active        per-slot active enable (registered)
//   o_initial_x/y      launch position, shared by all slots (registered)
//   o_initial_speed    constant launch speed
//   o_fire_accepted    one-clock pulse when a launch is issued
//   o_fire_denied      one-clock pulse when a request finds no free slot
//   o_free_count       number of inactive slots
// ----------------------------------------------------------------------------
module rocket_launch_manager #(
    parameter int unsigned NUM_ROCKETS     = 4,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int          ROCKET_SPEED    = -256,
    parameter int          X_OFFSET        = 15,
    parameter int          Y_OFFSET        = -10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start_of_frame,
    input  logic                   i_fire_request,
    input  logic signed [10:0]     i_ship_x,
    input  logic signed [10:0]     i_ship_y,
    input  logic [NUM_ROCKETS-1:0] i_reached_border,
    input  logic [NUM_ROCKETS-1:0] i_rocket_hit,
    output logic [NUM_ROCKETS-1:0] o_is_active,
    output logic signed [10:0]     o_initial_x,
    output logic signed [10:0]     o_initial_y,
    output logic signed [10:0]     o_initial_speed,
    output logic                   o_fire_accepted,
    output logic                   o_fire_denied,
    output logic [3:0]             o_free_count
);

    localparam int unsigned CntW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic signed [10:0] XOff  = 11'(X_OFFSET);
    localparam logic signed [10:0] YOff  = 11'(Y_OFFSET);
    localparam logic signed [10:0] Speed = 11'(ROCKET_SPEED);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StCooldown
    } state_e;

    state_e                   r_state;
    logic [CntW-1:0]          r_cnt;
    logic [NUM_ROCKETS-1:0]   r_is_active;
    logic signed [10:0]       r_x;
    logic signed [10:0]       r_y;
    logic                     r_acc;
    logic                     r_den;

    logic [NUM_ROCKETS-1:0]   w_pick;
    logic                     w_any_free;
    logic [NUM_ROCKETS-1:0]   w_set;
    logic [NUM_ROCKETS-1:0]   w_clear;
    logic signed [10:0]       w_launch_x;
    logic signed [10:0]       w_launch_y;
    logic [3:0]               w_free_count;

    // Lowest-index free slot, judged on the registered enables only so a
    // slot cleared this cycle cannot be relaunched until the next one.
    always_comb begin
        w_pick     = '0;
        w_any_free = 1'b0;
        for (int i = 0; i < int'(NUM_ROCKETS); i++) begin
            if (!r_is_active[i] && !w_any_free) begin
                w_pick[i]  = 1'b1;
                w_any_free = 1'b1;
            end
        end
    end

    always_comb begin
        w_free_count = '0;
        for (int i = 0; i < int'(NUM_ROCKETS); i++) begin
            w_free_count = w_free_count + {3'b000, ~r_is_active[i]};
        end
    end

    // Sums wrap modulo 2^11.
    assign w_launch_x = i_ship_x + XOff;
    assign w_launch_y = i_ship_y + YOff;

    // The picked slot is inactive, so it never overlaps a clear.
    assign w_set   = (r_state == StIdle && i_fire_request) ? w_pick : '0;
    assign w_clear = r_is_active & (i_reached_border | i_rocket_hit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_is_active <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_acc       <= 1'b0;
            r_den       <= 1'b0;
        end else begin
            r_acc       <= 1'b0;
            r_den       <= 1'b0;
            r_is_active <= (r_is_active & ~w_clear) | w_set;
            case (r_state)
                StIdle: begin
                    if (i_fire_request) begin
                        if (w_any_free) begin
                            r_x     <= w_launch_x;
                            r_y     <= w_launch_y;
                            r_acc   <= 1'b1;
                            r_state <= StLaunch;
                        end else begin
                            r_den <= 1'b1;
                        end
                    end
                end
                // Launch position is held through this cycle so the controller
                // samples it on its enable rising edge.
                StLaunch: begin
                    if (COOLDOWN_FRAMES == 0) begin
                        r_state <= StIdle;
                    end else begin
                        r_state <= StCooldown;
                        r_cnt   <= CntW'(COOLDOWN_FRAMES);
                    end
                end
                // Requests are dropped here, not queued and not denied.
                StCooldown: begin
                    if (i_start_of_frame) begin
                        if (r_cnt <= CntW'(1)) begin
                            r_state <= StIdle;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CntW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_is_active     = r_is_active;
    assign o_initial_x     = r_x;
    assign o_initial_y     = r_y;
    assign o_initial_speed = Speed;
    assign o_fire_accepted = r_acc;
    assign o_fire_denied   = r_den;
    assign o_free_count    = w_free_count;

endmodule

// File: tb/tb_rocket_launch_manager.sv
// ----------------------------------------------------------------------------
// tb_rocket_launch_manager
//
// Directed bench for rocket_launch_manager with default parameters. Inputs
// change 1 time unit after the rising edge; outputs are sampled at the same
// point, after the edge has settled.
// ----------------------------------------------------------------------------
module tb_rocket_launch_manager;

    logic               clk;
    logic               rst_n;
    logic               sof;
    logic               fire;
    logic signed [10:0] ship_x;
    logic signed [10:0] ship_y;
    logic [3:0]         border;
    logic [3:0]         hit;
    logic [3:0]         is_active;
    logic signed [10:0] init_x;
    logic signed [10:0] init_y;
    logic signed [10:0] init_speed;
    logic               accepted;
    logic               denied;
    logic [3:0]         free_count;

    int checks   = 0;
    int failures = 0;

    rocket_launch_manager dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start_of_frame (sof),
        .i_fire_request   (fire),
        .i_ship_x         (ship_x),
        .i_ship_y         (ship_y),
        .i_reached_border (border),
        .i_rocket_hit     (hit),
        .o_is_active      (is_active),
        .o_initial_x      (init_x),
        .o_initial_y      (init_y),
        .o_initial_speed  (init_speed),
        .o_fire_accepted  (accepted),
        .o_fire_denied    (denied),
        .o_free_count     (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start-of-frame pulse lasting a single clock.
    task automatic frame();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sof    = 1'b0;
        fire   = 1'b0;
        ship_x = '0;
        ship_y = '0;
        border = '0;
        hit    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_active", 32'(is_active), 32'h0);
        chk("rst_x", 32'(init_x), 32'h0);
        chk("rst_y", 32'(init_y), 32'h0);
        chk("rst_acc", 32'(accepted), 32'h0);
        chk("rst_den", 32'(denied), 32'h0);
        chk("rst_free", 32'(free_count), 32'd4);
        chk("speed", 32'(init_speed), 32'hFFFFFF00);

        // 1. First launch
        fire   = 1'b1;
        ship_x = 11'sd100;
        ship_y = 11'sd400;
        tick();
        chk("l1_active", 32'(is_active), 32'b0001);
        chk("l1_x", 32'(init_x), 32'd115);
        chk("l1_y", 32'(init_y), 32'd390);
        chk("l1_acc", 32'(accepted), 32'h1);
        chk("l1_free", 32'(free_count), 32'd3);
        tick();
        chk("l1_acc_pulse", 32'(accepted), 32'h0);
        chk("l1_x_hold", 32'(init_x), 32'd115);

        // 2. Held request waits out the 8-frame cooldown
        for (int i = 0; i < 7; i++) frame();
        chk("cd_7frames", 32'(is_active), 32'b0001);
        chk("cd_no_deny", 32'(denied), 32'h0);
        frame();
        chk("cd_8frames_idle", 32'(is_active), 32'b0001);
        tick();
        chk("l2_active", 32'(is_active), 32'b0011);
        chk("l2_acc", 32'(accepted), 32'h1);
        tick();
        for (int i = 0; i < 8; i++) frame();
        tick();
        chk("l3_active", 32'(is_active), 32'b0111);
        tick();
        for (int i = 0; i < 8; i++) frame();
        tick();
        chk("l4_active", 32'(is_active), 32'b1111);
        chk("l4_free", 32'(free_count), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) frame();

        // 3. Pool exhausted in IDLE
        tick();
        chk("deny_pulse", 32'(denied), 32'h1);
        chk("deny_acc", 32'(accepted), 32'h0);
        chk("deny_active", 32'(is_active), 32'b1111);
        fire = 1'b0;
        tick();
        chk("deny_clear", 32'(denied), 32'h0);

        // 4. Border clears slot 1, which is low for a clock before reuse
        border = 4'b0010;
        tick();
        border = 4'b0000;
        chk("border_clear", 32'(is_active), 32'b1101);
        chk("border_free", 32'(free_count), 32'd1);
        fire = 1'b1;
        tick();
        chk("reuse_active", 32'(is_active), 32'b1111);
        chk("reuse_acc", 32'(accepted), 32'h1);
        fire = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) frame();

        // 5. Simultaneous hit on slot 0 and launch into slot 2
        border = 4'b1100;
        tick();
        border = 4'b0000;
        chk("pre5_active", 32'(is_active), 32'b0011);
        fire = 1'b1;
        hit  = 4'b0001;
        tick();
        fire = 1'b0;
        hit  = 4'b0000;
        chk("hit_launch", 32'(is_active), 32'b0110);
        border = 4'b1000;
        tick();
        border = 4'b0000;
        chk("inactive_border", 32'(is_active), 32'b0110);

        // 6. Reset during cooldown with three slots active
        tick();
        for (int i = 0; i < 8; i++) frame();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        chk("pre6_active", 32'(is_active), 32'b0111);
        tick();
        frame();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_active", 32'(is_active), 32'h0);
        chk("arst_x", 32'(init_x), 32'h0);
        chk("arst_y", 32'(init_y), 32'h0);
        chk("arst_acc", 32'(accepted), 32'h0);
        chk("arst_free", 32'(free_count), 32'd4);
        tick();
        rst_n  = 1'b1;
        fire   = 1'b1;
        ship_x = 11'sd1020;
        ship_y = -11'sd1020;
        tick();
        chk("post_rst_active", 32'(is_active), 32'b0001);
        chk("post_rst_acc", 32'(accepted), 32'h1);
        chk("wrap_x", 32'(init_x), 32'hFFFFFC0B);
        chk("wrap_y", 32'(init_y), 32'd1018);
        fire = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
